mc_control_unit: RTL and testbench
==================================

// Module: mc_control_unit
// PURPOSE
//  Parametrised multicycle control FSM for the RV64 datapath (PC, IR, A/B, ALU_OUT, MDR, register bank, ula64).
//  Replaces the fixed-latency control unit: instruction and data memory go through a REQ/READY handshake
//  with a bounded wait and a timeout, and illegal or unsupported opcodes trap.
//  Subset: add, sub, and, addi, ld, sd, beq, bne (bne only when HAS_BNE=1), lui.
//  Purely control: it emits datapath enables and mux selects only.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for MEM_READY per request; exceeding it traps (1..255)
//  HAS_BNE      1   1: bne decoded; 0: bne traps as illegal
// PORTS
//  CLK           in   1  clock, rising edge
//  RESET         in   1  asynchronous, active-low reset
//  IR6_0         in   7  opcode from IR
//  IR14_12       in   3  funct3 from IR
//  IR31_25       in   7  funct7 from IR
//  ALU_Z         in   1  ula64 zero flag for the current ALU op
//  MEM_READY     in   1  memory completion for the outstanding IMEM_REQ/DMEM_REQ
//  IMEM_REQ      out  1  instruction read request
//  DMEM_REQ      out  1  data memory request
//  DMEM_WE       out  1  data request is a write (valid with DMEM_REQ)
//  IR_WIRE       out  1  load IR
//  LOAD_A/LOAD_B out  1  load A/B from register bank outputs
//  LOAD_ALU_OUT  out  1  load ALU_OUT register
//  LOAD_MDR      out  1  load MDR from data memory
//  PC_WRITE      out  1  load PC
//  PC_SRC        out  1  PC input mux: 0 ALU result, 1 ALU_OUT
//  ALU_SRCA      out  1  0 PC, 1 A
//  ALU_SRCB      out  2  00 B, 01 const 4, 10 sign-ext imm, 11 unused
//  ALU_SELECTOR  out  3  001 add, 010 sub, 011 and; all others unused
//  BANCO_WIRE    out  1  register bank write enable
//  MEM_TO_REG    out  2  writeback source: 00 ALU_OUT, 01 MDR, 10 sign-ext imm (lui)
//  TRAP          out  1  sticky fault indicator
//  TRAP_CAUSE    out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
// BEHAVIOUR
//  Reset (RESET=0, async): state=FETCH, wait counter=0, TRAP=0, TRAP_CAUSE=00.
//  Outputs are Moore decoded from state, except the enables qualified by MEM_READY/ALU_Z noted below.
//  Every output not asserted in the current state is 0.
//  States and transitions:
//   FETCH    IMEM_REQ=1; when MEM_READY: IR_WIRE=1 -> DECODE.
//   DECODE   LOAD_A=LOAD_B=1; ALU PC+imm (SRCA=0,SRCB=10,add), LOAD_ALU_OUT=1; dispatch on opcode:
//            0110011->EXEC_R (funct7/funct3: 0000000/000 add, 0100000/000 sub, 0000000/111 and; else TRAP)
//            0010011 f3=000->EXEC_I; 0000011 f3=011 or 0100011 f3=111->ADDR; 1100011 f3=000/001->BRANCH
//            0110111->WB_LUI; anything else->TRAP cause 01.
//   EXEC_R   SRCA=1, SRCB=00, op per funct, LOAD_ALU_OUT=1 -> WB_ALU.
//   EXEC_I   SRCA=1, SRCB=10, add, LOAD_ALU_OUT=1 -> WB_ALU.
//   WB_ALU   BANCO_WIRE=1, MEM_TO_REG=00 -> PC_INC.
//   WB_LUI   BANCO_WIRE=1, MEM_TO_REG=10 -> PC_INC.
//   ADDR     A+imm into ALU_OUT -> MEM_RD (load) or MEM_WR (store).
//   MEM_RD   DMEM_REQ=1, DMEM_WE=0; when MEM_READY: LOAD_MDR=1 -> WB_MEM.
//   WB_MEM   BANCO_WIRE=1, MEM_TO_REG=01 -> PC_INC.
//   MEM_WR   DMEM_REQ=1, DMEM_WE=1; when MEM_READY -> PC_INC.
//   BRANCH   SRCA=1, SRCB=00, sub. Taken = (beq & ALU_Z) | (bne & !ALU_Z).
//            Taken: PC_WRITE=1, PC_SRC=1 -> FETCH. Not taken -> PC_INC.
//   PC_INC   SRCA=0, SRCB=01, add, PC_WRITE=1, PC_SRC=0 -> FETCH.
//   TRAP     all strobes 0, TRAP=1; holds until reset.
//  Wait counter:
//   - Cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle MEM_READY=0 in those states.
//   - Reaching MEM_TIMEOUT with MEM_READY=0 -> TRAP, cause 10 (FETCH) or 11 (MEM_*). Request drops next cycle.
//   - MEM_READY=1 in the same cycle the count reaches MEM_TIMEOUT: completion wins, no trap.
//  Request handshake: REQ stays high and DMEM_WE stays stable until the MEM_READY cycle.
//   MEM_READY while no request is outstanding is ignored.
//  TRAP_CAUSE latches on trap entry. Async reset mid-request drops REQ immediately; FSM restarts in FETCH.
// TESTING
//  add x3,x1,x2 with MEM_READY tied 1 -> FETCH,DECODE,EXEC_R,WB_ALU,PC_INC; 5 cycles; BANCO_WIRE 1 cycle; PC_WRITE once.
//  ld, MEM_READY delayed 3 cycles per request -> DMEM_REQ high 4 cycles, LOAD_MDR 1 cycle, then WB_MEM MEM_TO_REG=01.
//  beq with ALU_Z=1 -> BRANCH PC_WRITE=1, PC_SRC=1, no PC_INC. ALU_Z=0 -> PC_INC. HAS_BNE=0 with bne -> TRAP_CAUSE=01.
//  MEM_READY held 0 in FETCH, MEM_TIMEOUT=16 -> TRAP=1, cause 10 after 16 wait cycles, IMEM_REQ 0 thereafter.
//  MEM_READY=1 on exactly the timeout cycle -> no trap.
//  Opcode 0x7F -> TRAP, cause 01. RESET pulsed low during MEM_WR -> DMEM_REQ=0 asynchronously, FETCH after release.

Source files
------------

// File: rtl/mc_control_unit_if.sv
// Memory request/ready handshake shared by instruction and data memory.
// The control unit is the master; the memory system answers with MEM_READY.
interface mc_control_unit_if;
    logic IMEM_REQ;
    logic DMEM_REQ;
    logic DMEM_WE;
    logic MEM_READY;

    modport master (
        output IMEM_REQ,
        output DMEM_REQ,
        output DMEM_WE,
        input  MEM_READY
    );

    modport slave (
        input  IMEM_REQ,
        input  DMEM_REQ,
        input  DMEM_WE,
        output MEM_READY
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle RV64 control FSM: handshaked memory with bounded wait,
// sticky trap on illegal opcode or memory timeout.
module mc_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          HAS_BNE     = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    mc_control_unit_if.master mem,
    input  logic [6:0]        IR6_0,
    input  logic [2:0]        IR14_12,
    input  logic [6:0]        IR31_25,
    input  logic              ALU_Z,
    output logic              IR_WIRE,
    output logic              LOAD_A,
    output logic              LOAD_B,
    output logic              LOAD_ALU_OUT,
    output logic              LOAD_MDR,
    output logic              PC_WRITE,
    output logic              PC_SRC,
    output logic              ALU_SRCA,
    output logic [1:0]        ALU_SRCB,
    output logic [2:0]        ALU_SELECTOR,
    output logic              BANCO_WIRE,
    output logic [1:0]        MEM_TO_REG,
    output logic              TRAP,
    output logic [1:0]        TRAP_CAUSE
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    localparam logic [1:0] C_ILL  = 2'b01;
    localparam logic [1:0] C_IMEM = 2'b10;
    localparam logic [1:0] C_DMEM = 2'b11;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_ALU,
        S_WB_LUI,
        S_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_PC_INC,
        S_TRAP
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic       r_trap;
    logic [1:0] r_cause;
    logic [1:0] w_cause;

    logic w_r_add;
    logic w_r_sub;
    logic w_r_and;
    logic w_is_r;
    logic w_is_addi;
    logic w_is_ld;
    logic w_is_sd;
    logic w_is_beq;
    logic w_is_bne;
    logic w_is_lui;
    logic w_legal;
    logic w_taken;
    logic w_wait;
    logic w_tmo;
    logic [2:0] w_rop;

    always_comb begin
        w_r_add   = IR6_0 == OP_R && IR31_25 == 7'b0000000
                    && IR14_12 == 3'b000;
        w_r_sub   = IR6_0 == OP_R && IR31_25 == 7'b0100000
                    && IR14_12 == 3'b000;
        w_r_and   = IR6_0 == OP_R && IR31_25 == 7'b0000000
                    && IR14_12 == 3'b111;
        w_is_r    = w_r_add || w_r_sub || w_r_and;
        w_is_addi = IR6_0 == OP_I && IR14_12 == 3'b000;
        w_is_ld   = IR6_0 == OP_LD && IR14_12 == 3'b011;
        w_is_sd   = IR6_0 == OP_SD && IR14_12 == 3'b111;
        w_is_beq  = IR6_0 == OP_BR && IR14_12 == 3'b000;
        w_is_bne  = IR6_0 == OP_BR && IR14_12 == 3'b001
                    && HAS_BNE;
        w_is_lui  = IR6_0 == OP_LUI;
        w_legal   = w_is_r || w_is_addi || w_is_ld || w_is_sd
                    || w_is_beq || w_is_bne || w_is_lui;
        w_taken   = (w_is_beq && ALU_Z) || (w_is_bne && !ALU_Z);
        w_rop     = w_r_sub ? ALU_SUB : (w_r_and ? ALU_AND : ALU_ADD);
    end

    // Timeout fires on the request cycle whose miss would bring the
    // count to MEM_TIMEOUT; a READY in that same cycle still completes.
    always_comb begin
        w_wait = r_state == S_FETCH || r_state == S_MEM_RD
                 || r_state == S_MEM_WR;
        w_tmo  = w_wait && !mem.MEM_READY && r_cnt == TMO_LAST;
    end

    always_comb begin
        w_next  = r_state;
        w_cause = 2'b00;
        case (r_state)
            S_FETCH: begin
                if (mem.MEM_READY) begin
                    w_next = S_DECODE;
                end else if (w_tmo) begin
                    w_next  = S_TRAP;
                    w_cause = C_IMEM;
                end
            end
            S_DECODE: begin
                if (!w_legal) begin
                    w_next  = S_TRAP;
                    w_cause = C_ILL;
                end else begin
                    unique case (1'b1)
                        w_is_r:               w_next = S_EXEC_R;
                        w_is_addi:            w_next = S_EXEC_I;
                        w_is_ld || w_is_sd:   w_next = S_ADDR;
                        w_is_beq || w_is_bne: w_next = S_BRANCH;
                        w_is_lui:             w_next = S_WB_LUI;
                        default: begin
                            w_next  = S_TRAP;
                            w_cause = C_ILL;
                        end
                    endcase
                end
            end
            S_EXEC_R: w_next = S_WB_ALU;
            S_EXEC_I: w_next = S_WB_ALU;
            S_WB_ALU: w_next = S_PC_INC;
            S_WB_LUI: w_next = S_PC_INC;
            S_WB_MEM: w_next = S_PC_INC;
            S_ADDR:   w_next = w_is_ld ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem.MEM_READY) begin
                    w_next = S_WB_MEM;
                end else if (w_tmo) begin
                    w_next  = S_TRAP;
                    w_cause = C_DMEM;
                end
            end
            S_MEM_WR: begin
                if (mem.MEM_READY) begin
                    w_next = S_PC_INC;
                end else if (w_tmo) begin
                    w_next  = S_TRAP;
                    w_cause = C_DMEM;
                end
            end
            S_BRANCH: w_next = w_taken ? S_FETCH : S_PC_INC;
            S_PC_INC: w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    // Counter is zero whenever a request state is entered, since every
    // non-waiting cycle and every completed request clears it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_FETCH;
            r_cnt   <= 8'd0;
            r_trap  <= 1'b0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_wait && !mem.MEM_READY && !w_tmo) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    always_comb begin
        mem.IMEM_REQ = 1'b0;
        mem.DMEM_REQ = 1'b0;
        mem.DMEM_WE  = 1'b0;
        IR_WIRE      = 1'b0;
        LOAD_A       = 1'b0;
        LOAD_B       = 1'b0;
        LOAD_ALU_OUT = 1'b0;
        LOAD_MDR     = 1'b0;
        PC_WRITE     = 1'b0;
        PC_SRC       = 1'b0;
        ALU_SRCA     = 1'b0;
        ALU_SRCB     = 2'b00;
        ALU_SELECTOR = 3'b000;
        BANCO_WIRE   = 1'b0;
        MEM_TO_REG   = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem.IMEM_REQ = 1'b1;
                IR_WIRE      = mem.MEM_READY;
            end
            S_DECODE: begin
                LOAD_A       = 1'b1;
                LOAD_B       = 1'b1;
                ALU_SRCB     = 2'b10;
                ALU_SELECTOR = ALU_ADD;
                LOAD_ALU_OUT = 1'b1;
            end
            S_EXEC_R: begin
                ALU_SRCA     = 1'b1;
                ALU_SELECTOR = w_rop;
                LOAD_ALU_OUT = 1'b1;
            end
            S_EXEC_I, S_ADDR: begin
                ALU_SRCA     = 1'b1;
                ALU_SRCB     = 2'b10;
                ALU_SELECTOR = ALU_ADD;
                LOAD_ALU_OUT = 1'b1;
            end
            S_WB_ALU: BANCO_WIRE = 1'b1;
            S_WB_LUI: begin
                BANCO_WIRE = 1'b1;
                MEM_TO_REG = 2'b10;
            end
            S_WB_MEM: begin
                BANCO_WIRE = 1'b1;
                MEM_TO_REG = 2'b01;
            end
            S_MEM_RD: begin
                mem.DMEM_REQ = 1'b1;
                LOAD_MDR     = mem.MEM_READY;
            end
            S_MEM_WR: begin
                mem.DMEM_REQ = 1'b1;
                mem.DMEM_WE  = 1'b1;
            end
            S_BRANCH: begin
                ALU_SRCA     = 1'b1;
                ALU_SELECTOR = ALU_SUB;
                PC_WRITE     = w_taken;
                PC_SRC       = w_taken;
            end
            S_PC_INC: begin
                ALU_SRCB     = 2'b01;
                ALU_SELECTOR = ALU_ADD;
                PC_WRITE     = 1'b1;
            end
            default: ;
        endcase
    end

    assign TRAP       = r_trap;
    assign TRAP_CAUSE = r_cause;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle vector table plus
// hand sequences for timeouts, trap and async reset.
module tb_mc_control_unit;

    localparam logic [21:0] IMEM = 22'(1) << 21;
    localparam logic [21:0] DREQ = 22'(1) << 20;
    localparam logic [21:0] DWE  = 22'(1) << 19;
    localparam logic [21:0] IRW  = 22'(1) << 18;
    localparam logic [21:0] LA   = 22'(1) << 17;
    localparam logic [21:0] LB   = 22'(1) << 16;
    localparam logic [21:0] LALU = 22'(1) << 15;
    localparam logic [21:0] LMDR = 22'(1) << 14;
    localparam logic [21:0] PCW  = 22'(1) << 13;
    localparam logic [21:0] PCS  = 22'(1) << 12;
    localparam logic [21:0] SRCA = 22'(1) << 11;
    localparam logic [21:0] SB4  = 22'(1) << 9;
    localparam logic [21:0] SBIM = 22'(2) << 9;
    localparam logic [21:0] ADD  = 22'(1) << 6;
    localparam logic [21:0] SUB  = 22'(2) << 6;
    localparam logic [21:0] AND  = 22'(3) << 6;
    localparam logic [21:0] BW   = 22'(1) << 5;
    localparam logic [21:0] M2M  = 22'(1) << 3;
    localparam logic [21:0] M2L  = 22'(2) << 3;
    localparam logic [21:0] TRP  = 22'(1) << 2;

    localparam logic [21:0] F_W  = IMEM;
    localparam logic [21:0] F_R  = IMEM | IRW;
    localparam logic [21:0] DEC  = LA | LB | LALU | SBIM | ADD;
    localparam logic [21:0] XRA  = SRCA | ADD | LALU;
    localparam logic [21:0] XRS  = SRCA | SUB | LALU;
    localparam logic [21:0] XRN  = SRCA | AND | LALU;
    localparam logic [21:0] XI   = SRCA | SBIM | ADD | LALU;
    localparam logic [21:0] WBA  = BW;
    localparam logic [21:0] WBL  = BW | M2L;
    localparam logic [21:0] WBM  = BW | M2M;
    localparam logic [21:0] MR_W = DREQ;
    localparam logic [21:0] MR_R = DREQ | LMDR;
    localparam logic [21:0] MW   = DREQ | DWE;
    localparam logic [21:0] BRN  = SRCA | SUB;
    localparam logic [21:0] BRT  = SRCA | SUB | PCW | PCS;
    localparam logic [21:0] INC  = SB4 | ADD | PCW;
    localparam logic [21:0] TR1  = TRP | 22'd1;
    localparam logic [21:0] TR2  = TRP | 22'd2;
    localparam logic [21:0] TR3  = TRP | 22'd3;

    localparam logic [6:0] OR_ = 7'b0110011;
    localparam logic [6:0] OI  = 7'b0010011;
    localparam logic [6:0] OL  = 7'b0000011;
    localparam logic [6:0] OS  = 7'b0100011;
    localparam logic [6:0] OB  = 7'b1100011;
    localparam logic [6:0] OU  = 7'b0110111;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        logic        rdy;
        logic [21:0] exp;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [6:0] ir_op = '0;
    logic [2:0] ir_f3 = '0;
    logic [6:0] ir_f7 = '0;
    logic       alu_z = 1'b0;
    logic       rdy = 1'b0;

    int n_pass = 0;
    int n_tot  = 0;
    vec_t tbl[$];

    always #5 CLK = ~CLK;

    mc_control_unit_if mif();
    mc_control_unit_if mif0();
    assign mif.MEM_READY  = rdy;
    assign mif0.MEM_READY = rdy;

    logic       irw, la, lb, lalu, lmdr, pcw, pcs, srca, bw, trp;
    logic [1:0] srcb, m2r, cause;
    logic [2:0] sel;
    logic       irw0, la0, lb0, lalu0, lmdr0, pcw0, pcs0, srca0;
    logic       bw0, trp0;
    logic [1:0] srcb0, m2r0, cause0;
    logic [2:0] sel0;

    mc_control_unit #(.MEM_TIMEOUT(16), .HAS_BNE(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .mem(mif),
        .IR6_0(ir_op), .IR14_12(ir_f3), .IR31_25(ir_f7),
        .ALU_Z(alu_z), .IR_WIRE(irw), .LOAD_A(la), .LOAD_B(lb),
        .LOAD_ALU_OUT(lalu), .LOAD_MDR(lmdr), .PC_WRITE(pcw),
        .PC_SRC(pcs), .ALU_SRCA(srca), .ALU_SRCB(srcb),
        .ALU_SELECTOR(sel), .BANCO_WIRE(bw), .MEM_TO_REG(m2r),
        .TRAP(trp), .TRAP_CAUSE(cause)
    );

    mc_control_unit #(.MEM_TIMEOUT(16), .HAS_BNE(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET), .mem(mif0),
        .IR6_0(ir_op), .IR14_12(ir_f3), .IR31_25(ir_f7),
        .ALU_Z(alu_z), .IR_WIRE(irw0), .LOAD_A(la0), .LOAD_B(lb0),
        .LOAD_ALU_OUT(lalu0), .LOAD_MDR(lmdr0), .PC_WRITE(pcw0),
        .PC_SRC(pcs0), .ALU_SRCA(srca0), .ALU_SRCB(srcb0),
        .ALU_SELECTOR(sel0), .BANCO_WIRE(bw0), .MEM_TO_REG(m2r0),
        .TRAP(trp0), .TRAP_CAUSE(cause0)
    );

    logic [21:0] obs, obs0;
    assign obs = {mif.IMEM_REQ, mif.DMEM_REQ, mif.DMEM_WE, irw, la,
                  lb, lalu, lmdr, pcw, pcs, srca, srcb, sel, bw, m2r,
                  trp, cause};
    assign obs0 = {mif0.IMEM_REQ, mif0.DMEM_REQ, mif0.DMEM_WE, irw0,
                   la0, lb0, lalu0, lmdr0, pcw0, pcs0, srca0, srcb0,
                   sel0, bw0, m2r0, trp0, cause0};

    function automatic vec_t v(input logic [6:0] op,
                               input logic [2:0] f3,
                               input logic [6:0] f7,
                               input logic z, input logic r,
                               input logic [21:0] e);
        vec_t x;
        x.op = op; x.f3 = f3; x.f7 = f7;
        x.z = z; x.rdy = r; x.exp = e;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [21:0] act,
                       input logic [21:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input vec_t x);
        ir_op = x.op; ir_f3 = x.f3; ir_f7 = x.f7;
        alu_z = x.z; rdy = x.rdy;
    endtask

    task automatic step(input vec_t x, input string nm);
        drive(x);
        @(negedge CLK);
        chk(nm, obs, x.exp);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rdy = 1'b0;
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_state", obs, F_W);
        RESET = 1'b1;
    endtask

    initial begin
        // add, sub, and, addi, lui with READY tied high
        tbl.push_back(v(OR_, 3'd0, 7'h00, 0, 1, F_R));
        tbl.push_back(v(OR_, 3'd0, 7'h00, 0, 1, DEC));
        tbl.push_back(v(OR_, 3'd0, 7'h00, 0, 1, XRA));
        tbl.push_back(v(OR_, 3'd0, 7'h00, 0, 1, WBA));
        tbl.push_back(v(OR_, 3'd0, 7'h00, 0, 1, INC));
        tbl.push_back(v(OR_, 3'd0, 7'h20, 0, 1, F_R));
        tbl.push_back(v(OR_, 3'd0, 7'h20, 0, 1, DEC));
        tbl.push_back(v(OR_, 3'd0, 7'h20, 0, 1, XRS));
        tbl.push_back(v(OR_, 3'd0, 7'h20, 0, 1, WBA));
        tbl.push_back(v(OR_, 3'd0, 7'h20, 0, 1, INC));
        tbl.push_back(v(OR_, 3'd7, 7'h00, 0, 1, F_R));
        tbl.push_back(v(OR_, 3'd7, 7'h00, 0, 1, DEC));
        tbl.push_back(v(OR_, 3'd7, 7'h00, 0, 1, XRN));
        tbl.push_back(v(OR_, 3'd7, 7'h00, 0, 1, WBA));
        tbl.push_back(v(OR_, 3'd7, 7'h00, 0, 1, INC));
        tbl.push_back(v(OI, 3'd0, 7'h00, 0, 1, F_R));
        tbl.push_back(v(OI, 3'd0, 7'h00, 0, 1, DEC));
        tbl.push_back(v(OI, 3'd0, 7'h00, 0, 1, XI));
        tbl.push_back(v(OI, 3'd0, 7'h00, 0, 1, WBA));
        tbl.push_back(v(OI, 3'd0, 7'h00, 0, 1, INC));
        tbl.push_back(v(OU, 3'd0, 7'h00, 0, 1, F_R));
        tbl.push_back(v(OU, 3'd0, 7'h00, 0, 1, DEC));
        tbl.push_back(v(OU, 3'd0, 7'h00, 0, 1, WBL));
        tbl.push_back(v(OU, 3'd0, 7'h00, 0, 1, INC));
        // ld with READY three cycles late on both requests
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(OL, 3'd3, 7'h00, 0, 0, F_W));
        tbl.push_back(v(OL, 3'd3, 7'h00, 0, 1, F_R));
        tbl.push_back(v(OL, 3'd3, 7'h00, 0, 1, DEC));
        tbl.push_back(v(OL, 3'd3, 7'h00, 0, 1, XI));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(OL, 3'd3, 7'h00, 0, 0, MR_W));
        tbl.push_back(v(OL, 3'd3, 7'h00, 0, 1, MR_R));
        tbl.push_back(v(OL, 3'd3, 7'h00, 0, 1, WBM));
        tbl.push_back(v(OL, 3'd3, 7'h00, 0, 1, INC));
        // sd
        tbl.push_back(v(OS, 3'd7, 7'h00, 0, 1, F_R));
        tbl.push_back(v(OS, 3'd7, 7'h00, 0, 1, DEC));
        tbl.push_back(v(OS, 3'd7, 7'h00, 0, 1, XI));
        tbl.push_back(v(OS, 3'd7, 7'h00, 0, 0, MW));
        tbl.push_back(v(OS, 3'd7, 7'h00, 0, 1, MW));
        tbl.push_back(v(OS, 3'd7, 7'h00, 0, 1, INC));
        // beq taken goes straight back to FETCH
        tbl.push_back(v(OB, 3'd0, 7'h00, 1, 1, F_R));
        tbl.push_back(v(OB, 3'd0, 7'h00, 1, 1, DEC));
        tbl.push_back(v(OB, 3'd0, 7'h00, 1, 1, BRT));
        tbl.push_back(v(OB, 3'd0, 7'h00, 0, 1, F_R));
        tbl.push_back(v(OB, 3'd0, 7'h00, 0, 1, DEC));
        tbl.push_back(v(OB, 3'd0, 7'h00, 0, 1, BRN));
        tbl.push_back(v(OB, 3'd0, 7'h00, 0, 1, INC));
        tbl.push_back(v(OB, 3'd1, 7'h00, 0, 1, F_R));
        tbl.push_back(v(OB, 3'd1, 7'h00, 0, 1, DEC));
        tbl.push_back(v(OB, 3'd1, 7'h00, 0, 1, BRT));
        tbl.push_back(v(OB, 3'd1, 7'h00, 1, 1, F_R));
        tbl.push_back(v(OB, 3'd1, 7'h00, 1, 1, DEC));
        tbl.push_back(v(OB, 3'd1, 7'h00, 1, 1, BRN));
        tbl.push_back(v(OB, 3'd1, 7'h00, 1, 1, INC));
        // R-type with unsupported funct7 traps and stays trapped
        tbl.push_back(v(OR_, 3'd0, 7'h01, 0, 1, F_R));
        tbl.push_back(v(OR_, 3'd0, 7'h01, 0, 1, DEC));
        tbl.push_back(v(OR_, 3'd0, 7'h01, 0, 1, TR1));
        tbl.push_back(v(OR_, 3'd0, 7'h01, 0, 0, TR1));

        do_reset();
        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // IMEM timeout: 16 unanswered request cycles, then trap
        do_reset();
        for (int i = 0; i < 16; i++)
            step(v(OI, 3'd0, 7'h00, 0, 0, F_W), "imem_wait");
        step(v(OI, 3'd0, 7'h00, 0, 0, TR2), "imem_tmo");
        step(v(OI, 3'd0, 7'h00, 0, 1, TR2), "imem_tmo_hold");

        // READY on the timeout cycle completes the fetch
        do_reset();
        for (int i = 0; i < 15; i++)
            step(v(OI, 3'd0, 7'h00, 0, 0, F_W), "edge_wait");
        step(v(OI, 3'd0, 7'h00, 0, 1, F_R), "edge_ready");
        step(v(OI, 3'd0, 7'h00, 0, 1, DEC), "edge_dec");
        step(v(OI, 3'd0, 7'h00, 0, 1, XI), "edge_exec");

        // DMEM timeout on a load
        do_reset();
        step(v(OL, 3'd3, 7'h00, 0, 1, F_R), "dtmo_f");
        step(v(OL, 3'd3, 7'h00, 0, 1, DEC), "dtmo_dec");
        step(v(OL, 3'd3, 7'h00, 0, 1, XI), "dtmo_addr");
        for (int i = 0; i < 16; i++)
            step(v(OL, 3'd3, 7'h00, 0, 0, MR_W), "dtmo_wait");
        step(v(OL, 3'd3, 7'h00, 0, 0, TR3), "dmem_tmo");

        // bne: decoded with HAS_BNE=1, illegal with HAS_BNE=0
        do_reset();
        drive(v(OB, 3'd1, 7'h00, 0, 1, '0));
        @(negedge CLK);
        chk("bne0_fetch", obs0, F_R);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("bne0_dec", obs0, DEC);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("bne1_branch", obs, BRT);
        chk("bne0_trap", obs0, TR1);
        @(posedge CLK); #1;

        // unknown opcode 0x7F
        do_reset();
        step(v(7'h7F, 3'd0, 7'h00, 0, 1, F_R), "op7f_f");
        step(v(7'h7F, 3'd0, 7'h00, 0, 1, DEC), "op7f_dec");
        step(v(7'h7F, 3'd0, 7'h00, 0, 1, TR1), "op7f_trap");
        step(v(OI, 3'd0, 7'h00, 0, 1, TR1), "op7f_hold");

        // async reset in the middle of a store request
        do_reset();
        step(v(OS, 3'd7, 7'h00, 0, 1, F_R), "rst_f");
        step(v(OS, 3'd7, 7'h00, 0, 1, DEC), "rst_dec");
        step(v(OS, 3'd7, 7'h00, 0, 1, XI), "rst_addr");
        drive(v(OS, 3'd7, 7'h00, 0, 0, '0));
        @(negedge CLK);
        chk("rst_mw", obs, MW);
        #2;
        RESET = 1'b0;
        #1;
        chk("rst_async", obs, F_W);
        @(posedge CLK); #1;
        RESET = 1'b1;
        step(v(OS, 3'd7, 7'h00, 0, 1, F_R), "rst_refetch");
        step(v(OS, 3'd7, 7'h00, 0, 1, DEC), "rst_redec");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
